// File: rtl/switch_debouncer_pkg.sv
// Shared defaults and the counter-width helper for the switch debouncer.
package switch_debouncer_pkg;

  localparam int DEFAULT_WIDTH         = 8;
  localparam int DEFAULT_SYNC_STAGES   = 2;
  localparam int DEFAULT_STABLE_CYCLES = 1000000;
  localparam int SIM_STABLE_CYCLES     = 4;

  // Enough bits to hold 0..stable_cycles; never narrower than one bit.
  function automatic int counter_width(input int stable_cycles);
    return (stable_cycles < 1) ? 1 : $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: synchroniser chain, stability counter and accepted level.
// accept is high during the cycle whose closing edge updates level.
module debounce_bit
  import switch_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic accept
);

  localparam int CW = counter_width(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [CW-1:0]          cnt_reg;
  logic                   level_reg;
  logic                   s;

  assign s      = sync_reg[SYNC_STAGES-1];
  assign level  = level_reg;
  assign accept = (s != level_reg) && (cnt_reg == LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_reg  <= '0;
      cnt_reg   <= '0;
      level_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
      // Any return to the accepted level forfeits all accumulated credit.
      if (s == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == LAST) begin
        level_reg <= s;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// Synchronises and debounces WIDTH slide switches, with a change strobe and mask.
// Define CHANGE_COUNT_EN to add the 8-bit wrapping accepted-change counter.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_out,
  output logic             changed,
  output logic [WIDTH-1:0] changed_mask
`ifdef CHANGE_COUNT_EN
  ,
  output logic [7:0]       change_count
`endif
);

  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] mask_reg;
  logic             changed_reg;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      debounce_bit #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES)
      ) u_bit (
        .clock (clock),
        .reset (reset),
        .raw   (sw_raw[gi]),
        .level (sw_out[gi]),
        .accept(accept[gi])
      );
    end
  endgenerate

  // Registered alongside sw_out so strobe and mask line up with the new value.
  always_ff @(posedge clock) begin
    if (reset) begin
      mask_reg    <= '0;
      changed_reg <= 1'b0;
    end else begin
      mask_reg    <= accept;
      changed_reg <= |accept;
    end
  end

  assign changed      = changed_reg;
  assign changed_mask = mask_reg;

`ifdef CHANGE_COUNT_EN
  logic [7:0] count_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= 8'd0;
    end else if (|accept) begin
      count_reg <= count_reg + 8'd1;
    end
  end

  assign change_count = count_reg;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer with SYNC_STAGES=2, STABLE_CYCLES=4.
module tb_switch_debouncer;
  import switch_debouncer_pkg::*;

  localparam int SYNC = 2;
  localparam int STAB = SIM_STABLE_CYCLES;
  localparam int LAT  = SYNC + STAB;

  logic       clock;
  logic       reset;
  logic [7:0] sw_raw;
  logic [7:0] sw_out;
  logic       changed;
  logic [7:0] changed_mask;
`ifdef CHANGE_COUNT_EN
  logic [7:0] change_count;
`endif

  switch_debouncer #(
    .WIDTH        (8),
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STAB)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .sw_raw      (sw_raw),
    .sw_out      (sw_out),
    .changed     (changed),
    .changed_mask(changed_mask)
`ifdef CHANGE_COUNT_EN
    ,
    .change_count(change_count)
`endif
  );

  typedef struct {
    logic [7:0] value;
    logic [7:0] mask;
    int         at_edge;
  } exp_t;

  exp_t q[$];
  exp_t mon_exp;
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  bit   mon_en = 0;
  logic [7:0] cur;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Called at the negedge where sw_raw is driven; the update is due LAT edges later.
  task automatic push_exp(input logic [7:0] value, input logic [7:0] mask);
    exp_t e;
    e.value   = value;
    e.mask    = mask;
    e.at_edge = edge_cnt + LAT;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (mon_en) begin
      if (q.size() > 0 && q[0].at_edge < edge_cnt) begin
        check("late_update", edge_cnt, q[0].at_edge);
        void'(q.pop_front());
      end
      if (changed) begin
        if (q.size() == 0) begin
          check("spurious_strobe", {31'd0, changed}, 32'd0);
        end else begin
          mon_exp = q.pop_front();
          $display("txn edge=%0d sw_out=%02h mask=%02h (want %02h/%02h @%0d)",
                   edge_cnt, sw_out, changed_mask, mon_exp.value, mon_exp.mask, mon_exp.at_edge);
          check("sw_out", {24'd0, sw_out}, {24'd0, mon_exp.value});
          check("changed_mask", {24'd0, changed_mask}, {24'd0, mon_exp.mask});
          check("update_edge", edge_cnt, mon_exp.at_edge);
        end
      end else begin
        check("idle_mask", {24'd0, changed_mask}, 32'd0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    sw_raw = 8'hFF;
    @(negedge clock);
    mon_en = 1'b1;
    repeat (3) begin
      check("rst_sw_out", {24'd0, sw_out}, 32'd0);
      check("rst_changed", {31'd0, changed}, 32'd0);
      check("rst_mask", {24'd0, changed_mask}, 32'd0);
      @(negedge clock);
    end
    reset = 1'b0;
    push_exp(8'hFF, 8'hFF);
    idle(10);

    sw_raw = 8'h00; push_exp(8'h00, 8'hFF); idle(10);
    sw_raw = 8'hA5; push_exp(8'hA5, 8'hA5); idle(10);
    sw_raw = 8'h00; push_exp(8'h00, 8'hA5); idle(10);

    // Three-cycle glitch on bit0 must be rejected
    sw_raw = 8'h01; idle(3);
    sw_raw = 8'h00; idle(10);
    check("glitch_sw_out", {24'd0, sw_out}, 32'd0);

    // Four-cycle pulse on bit0 is accepted, then its fall too
    sw_raw = 8'h01; push_exp(8'h01, 8'h01); idle(4);
    sw_raw = 8'h00; push_exp(8'h00, 8'h01); idle(12);

    // Bounce on bit3, final rise held
    sw_raw = 8'h08; idle(1);
    sw_raw = 8'h00; idle(1);
    sw_raw = 8'h08; idle(1);
    sw_raw = 8'h00; idle(1);
    sw_raw = 8'h08; push_exp(8'h08, 8'h08); idle(10);
    sw_raw = 8'h00; push_exp(8'h00, 8'h08); idle(10);

    // Reset in the middle of qualification
    sw_raw = 8'h0F; idle(2);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clock);
      check("midrst_sw_out", {24'd0, sw_out}, 32'd0);
      check("midrst_changed", {31'd0, changed}, 32'd0);
    end
    reset = 1'b0;
    push_exp(8'h0F, 8'h0F);
    idle(10);
    check("post_rst_sw_out", {24'd0, sw_out}, 32'h0F);

`ifdef CHANGE_COUNT_EN
    reset  = 1'b1;
    sw_raw = 8'h00;
    idle(2);
    check("cnt_reset", {24'd0, change_count}, 32'd0);
    reset = 1'b0;
    sw_raw = 8'h01; push_exp(8'h01, 8'h01); idle(8);
    sw_raw = 8'h1F; push_exp(8'h1F, 8'h1E); idle(8);
    check("cnt_two", {24'd0, change_count}, 32'd2);
    cur = 8'h1F;
    for (int i = 0; i < 254; i++) begin
      cur    = cur ^ 8'h01;
      sw_raw = cur;
      push_exp(cur, 8'h01);
      idle(7);
    end
    check("cnt_wrap", {24'd0, change_count}, 32'd0);
`endif

    idle(10);
    check("queue_drain", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
